// File: rtl/uart_result_reporter.sv
// Latches a binary frame and digit on start, then streams SYNC0,SYNC1,digit,image bytes through uart_tx.
// Build option REPORT_CSUM_EN appends an XOR checksum byte covering the digit and image bytes.
module uart_result_reporter #(
  parameter logic [7:0] SYNC0       = 8'hA5,
  parameter logic [7:0] SYNC1       = 8'h5A,
  parameter int         IMG_BITS    = 784,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IMG_BITS-1:0] img_in,
  input  logic [3:0]          digit,
  output logic                busy,
  output logic                done,
  output logic                ack_err,
  output logic                uart_start,
  output logic [7:0]          uart_data,
  input  logic                uart_busy
);

  localparam int IMG_BYTES = IMG_BITS / 8;
`ifdef REPORT_CSUM_EN
  localparam int NBYTES = IMG_BYTES + 4;
`else
  localparam int NBYTES = IMG_BYTES + 3;
`endif
  localparam logic [6:0] LAST_IDX = 7'(NBYTES - 1);
  localparam logic [6:0] IMG_LAST = 7'(IMG_BYTES + 2);
  localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam int         BW       = $clog2(IMG_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    ACK   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [IMG_BITS-1:0] img_q;
  logic [3:0]          digit_q;
  logic [6:0]          idx_q;
  logic [TW-1:0]       timer_q;
  logic                busy_q;
  logic                done_q;
  logic                ack_err_q;
  logic                uart_start_q;
  logic [7:0]          uart_data_q;
`ifdef REPORT_CSUM_EN
  logic [7:0]          csum_q;
`endif

  logic [6:0] img_idx;
  logic [7:0] byte_d;

  // Byte for the current packet index; anything past the image is the checksum slot.
  always_comb begin
    img_idx = idx_q - 7'd3;
    byte_d  = 8'h00;
    if (idx_q == 7'd0)
      byte_d = SYNC0;
    else if (idx_q == 7'd1)
      byte_d = SYNC1;
    else if (idx_q == 7'd2)
      byte_d = {4'h0, digit_q};
    else if (idx_q <= IMG_LAST)
      byte_d = img_q[BW'({img_idx, 3'b000}) +: 8];
`ifdef REPORT_CSUM_EN
    else
      byte_d = csum_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      img_q        <= '0;
      digit_q      <= 4'h0;
      idx_q        <= 7'd0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ack_err_q    <= 1'b0;
      uart_start_q <= 1'b0;
      uart_data_q  <= 8'h00;
`ifdef REPORT_CSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      uart_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            img_q     <= img_in;
            digit_q   <= digit;
            busy_q    <= 1'b1;
            ack_err_q <= 1'b0;
            idx_q     <= 7'd0;
`ifdef REPORT_CSUM_EN
            csum_q    <= 8'h00;
`endif
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (!uart_busy) begin
            uart_start_q <= 1'b1;
            uart_data_q  <= byte_d;
            timer_q      <= '0;
            state_q      <= ACK;
          end
        end
        ACK: begin
          if (uart_busy) begin
            state_q <= DRAIN;
          end else if (timer_q == TMO_LAST) begin
            // No retry: the byte is treated as sent and the fault is made sticky.
            ack_err_q <= 1'b1;
            state_q   <= DRAIN;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!uart_busy) begin
`ifdef REPORT_CSUM_EN
            if (idx_q >= 7'd2 && idx_q <= IMG_LAST)
              csum_q <= csum_q ^ uart_data_q;
`endif
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 7'd1;
              state_q <= SEND;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ack_err    = ack_err_q;
  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;

endmodule
